instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 145 ++++++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. Holds the fetch PC, issues one read at a time to
// instruction memory, registers the returned word for the decode stage, and
// handles decode back-pressure (stall) and taken-branch redirects from EXE.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   stall          decode cannot accept a new instruction this cycle
//   branch_taken   one-cycle redirect pulse
//   branch_target  redirect byte address (low two bits ignored)
//   imem_req       instruction memory read request
//   imem_addr      word-aligned read byte address
//   imem_ack       read data valid (same cycle as imem_req or later)
//   imem_rdata     instruction word, used only while imem_ack=1
//   instruction    registered instruction word for decode
//   pc_out         byte address of the word on instruction
//   instr_valid    instruction/pc_out hold a live instruction
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  // FETCH: fresh request at pc.  WAIT: request outstanding, address held.
  // HOLD: live instruction stalled, no request.  DROP: wrong-path request
  // still outstanding after a redirect; its data is discarded.
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr;
  logic [31:0] instr_next, pc_out_next;
  logic        valid_next;
  logic        capture;
  logic        hold_live;
  logic [31:0] target_aligned;

  assign target_aligned = branch_target & 32'hFFFF_FFFC;
  // A live instruction that decode refuses must not be overwritten.
  assign hold_live      = stall && instr_valid;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_next  = instruction;
    pc_out_next = pc_out;
    valid_next  = instr_valid;
    capture     = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = req_addr;

    case (state)
      FETCH: begin
        imem_addr = pc;
        imem_req  = !hold_live;
        if (branch_taken) begin
          // An unanswered request must still be drained before redirecting.
          state_next = (imem_req && !imem_ack) ? DROP : FETCH;
        end else if (hold_live) begin
          state_next = HOLD;
        end else if (imem_ack) begin
          capture = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          state_next = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          state_next = FETCH;
          // If decode is holding a live word, drop this one; pc is not
          // advanced so the same address is fetched again later.
          capture    = !hold_live;
        end
      end
      HOLD: begin
        if (branch_taken || !stall) state_next = FETCH;
      end
      DROP: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Redirect outranks capture and stall.
    if (branch_taken) begin
      pc_next    = target_aligned;
      valid_next = 1'b0;
    end else if (capture) begin
      instr_next  = imem_rdata;
      pc_out_next = pc;
      valid_next  = 1'b1;
      pc_next     = pc + 32'd4;
    end else if (!stall) begin
      // Decode consumed the word and nothing replaced it.
      valid_next = 1'b0;
    end

    if (rst) imem_req = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: all state here is control or pipeline data that must come up
      // known, so each register is reset; there is no storage array.
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instruction <= 32'h0;
      pc_out      <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      pc_out      <= pc_out_next;
      instr_valid <= valid_next;
      // Latch the issued address so WAIT/DROP keep it stable even after pc
      // is redirected.
      if (state == FETCH) req_addr <= pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;

  int tests = 0;
  int fails = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcout;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] t,
                     input logic a, input logic [31:0] rd,
                     input logic er, input logic ca, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.br = b; v.target = t; v.ack = a; v.rdata = rd;
    v.exp_req = er; v.chk_addr = ca; v.exp_addr = ea;
    v.exp_valid = ev; v.exp_pcout = ep; v.exp_instr = ei;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, check the request side before the edge and
  // the registered outputs just after it.
  task automatic step(input int idx, input vec_t v);
    stall         = v.stall;
    branch_taken  = v.br;
    branch_target = v.target;
    imem_ack      = v.ack;
    imem_rdata    = v.rdata;
    #1;
    check($sformatf("vec%0d.req", idx), {31'b0, imem_req}, {31'b0, v.exp_req});
    if (v.chk_addr) check($sformatf("vec%0d.addr", idx), imem_addr, v.exp_addr);
    @(posedge clk); #1;
    check($sformatf("vec%0d.valid", idx), {31'b0, instr_valid}, {31'b0, v.exp_valid});
    check($sformatf("vec%0d.pc_out", idx), pc_out, v.exp_pcout);
    check($sformatf("vec%0d.instr", idx), instruction, v.exp_instr);
  endtask

  // Contents of the random-phase memory: any address maps to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_next, prev_pcout, prev_instr, prev_addr;
    logic        prev_hold, prev_pending;
    int          consumed;
    vec_t        v;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #2;
    check("reset.req", {31'b0, imem_req}, 32'h0);
    check("reset.valid", {31'b0, instr_valid}, 32'h0);
    check("reset.pc_out", pc_out, 32'h0);
    check("reset.instr", instruction, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("first.req", {31'b0, imem_req}, 32'h1);
    check("first.addr", imem_addr, 32'h0);

    //   stall br target        ack rdata         req chk addr          valid pc_out        instr
    add(0, 0, 32'h0,          1, 32'h0000_FFFF, 1, 1, 32'h0,          1, 32'h0,          32'h0000_FFFF);
    add(0, 0, 32'h0,          1, 32'h0200_EEEE, 1, 1, 32'h4,          1, 32'h4,          32'h0200_EEEE);
    add(0, 0, 32'h0,          1, 32'h0640_0000, 1, 1, 32'h8,          1, 32'h8,          32'h0640_0000);
    add(0, 0, 32'h0,          0, 32'h0,         1, 1, 32'hC,          0, 32'h8,          32'h0640_0000);
    add(0, 0, 32'h0,          0, 32'h0,         1, 1, 32'hC,          0, 32'h8,          32'h0640_0000);
    add(0, 0, 32'h0,          1, 32'h0480_0000, 1, 1, 32'hC,          1, 32'hC,          32'h0480_0000);
    add(0, 0, 32'h0,          1, 32'h2200_0001, 1, 1, 32'h10,         1, 32'h10,         32'h2200_0001);
    add(1, 0, 32'h0,          0, 32'h0,         0, 0, 32'h0,          1, 32'h10,         32'h2200_0001);
    add(1, 0, 32'h0,          0, 32'h0,         0, 0, 32'h0,          1, 32'h10,         32'h2200_0001);
    add(1, 0, 32'h0,          0, 32'h0,         0, 0, 32'h0,          1, 32'h10,         32'h2200_0001);
    add(0, 0, 32'h0,          0, 32'h0,         0, 0, 32'h0,          0, 32'h10,         32'h2200_0001);
    add(0, 0, 32'h0,          1, 32'h1111_0014, 1, 1, 32'h14,         1, 32'h14,         32'h1111_0014);
    add(0, 0, 32'h0,          0, 32'h0,         1, 1, 32'h18,         0, 32'h14,         32'h1111_0014);
    add(0, 1, 32'h43,         0, 32'h0,         1, 1, 32'h18,         0, 32'h14,         32'h1111_0014);
    add(0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 1, 32'h18,         0, 32'h14,         32'h1111_0014);
    add(0, 0, 32'h0,          1, 32'h3333_0040, 1, 1, 32'h40,         1, 32'h40,         32'h3333_0040);
    add(0, 0, 32'h0,          0, 32'h0,         1, 1, 32'h44,         0, 32'h40,         32'h3333_0040);
    add(1, 1, 32'h100,        1, 32'hBAD0_0044, 1, 1, 32'h44,         0, 32'h40,         32'h3333_0040);
    add(0, 0, 32'h0,          1, 32'h4444_0100, 1, 1, 32'h100,        1, 32'h100,        32'h4444_0100);
    add(0, 1, 32'hFFFF_FFFE,  1, 32'hBAD0_0104, 1, 1, 32'h104,        0, 32'h100,        32'h4444_0100);
    add(0, 0, 32'h0,          1, 32'h5555_FFFC, 1, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  32'h5555_FFFC);
    add(0, 0, 32'h0,          1, 32'h6666_0000, 1, 1, 32'h0,          1, 32'h0,          32'h6666_0000);
    add(0, 0, 32'h0,          0, 32'h0,         1, 1, 32'h4,          0, 32'h0,          32'h6666_0000);
    add(0, 1, 32'h200,        0, 32'h0,         1, 1, 32'h4,          0, 32'h0,          32'h6666_0000);
    add(0, 1, 32'h300,        0, 32'h0,         1, 1, 32'h4,          0, 32'h0,          32'h6666_0000);
    add(0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 1, 32'h4,          0, 32'h0,          32'h6666_0000);
    add(0, 0, 32'h0,          1, 32'h7777_0300, 1, 1, 32'h300,        1, 32'h300,        32'h7777_0300);
    add(0, 0, 32'h0,          0, 32'h0,         1, 1, 32'h304,        0, 32'h300,        32'h7777_0300);

    foreach (vecs[i]) step(i, vecs[i]);

    // Reset while a request is outstanding; an ack during reset is ignored.
    stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rstwait.valid", {31'b0, instr_valid}, 32'h0);
    check("rstwait.pc_out", pc_out, 32'h0);
    check("rstwait.instr", instruction, 32'h0);
    check("rstwait.req", {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check("rstwait.late_valid", {31'b0, instr_valid}, 32'h0);
    check("rstwait.late_instr", instruction, 32'h0);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    check("rstwait.restart_req", {31'b0, imem_req}, 32'h1);
    check("rstwait.restart_addr", imem_addr, 32'h0);
    add(0, 0, 32'h0, 1, 32'h8888_0000, 1, 1, 32'h0, 1, 32'h0, 32'h8888_0000);
    v = vecs[vecs.size()-1];
    step(vecs.size()-1, v);

    // Randomized run against a stream-level model: every instruction handed
    // to decode must be the next address of the program flow and carry the
    // memory word for that address.
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_next = 32'h0; prev_hold = 1'b0; prev_pending = 1'b0; consumed = 0;
    prev_pcout = 32'h0; prev_instr = 32'h0; prev_addr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_hold) begin
        check("rnd.hold_valid", {31'b0, instr_valid}, 32'h1);
        check("rnd.hold_pc_out", pc_out, prev_pcout);
        check("rnd.hold_instr", instruction, prev_instr);
      end
      stall         = ($urandom_range(3) == 0);
      branch_taken  = ($urandom_range(15) == 0);
      branch_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      #1;
      imem_ack   = imem_req && ($urandom_range(2) != 0);
      imem_rdata = mem_word(imem_addr);
      #1;
      if (prev_pending) begin
        check("rnd.req_kept", {31'b0, imem_req}, 32'h1);
        check("rnd.addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) check("rnd.align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (instr_valid && !stall) begin
        check("rnd.pc_out", pc_out, exp_next);
        check("rnd.instr", instruction, mem_word(pc_out));
        exp_next = pc_out + 32'd4;
        consumed++;
      end
      if (branch_taken) exp_next = branch_target & 32'hFFFF_FFFC;
      prev_hold    = instr_valid && stall && !branch_taken;
      prev_pcout   = pc_out;
      prev_instr   = instruction;
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      @(posedge clk); #1;
    end
    check("rnd.progress", {31'b0, consumed > 300}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
